// File: rtl/music_player_pkg.sv
// Shared types, state encoding and the semitone half-period table for the
// music player and its tone generator.
package music_player_pkg;

    localparam int         HALF_W   = 17;
    localparam logic [7:0] REST_IDX = 8'd0;
    localparam logic [7:0] MAX_IDX  = 8'd14;

    typedef logic [7:0]        note_t;
    typedef logic [HALF_W-1:0] half_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_t;

    // Half-periods in 50 MHz clocks; index 1 is 220 Hz, one semitone per step.
    function automatic half_t half_table(input note_t idx);
        half_t h;
        case (idx)
            8'd1:    h = 17'd113636;
            8'd2:    h = 17'd107258;
            8'd3:    h = 17'd101238;
            8'd4:    h = 17'd95556;
            8'd5:    h = 17'd90193;
            8'd6:    h = 17'd85131;
            8'd7:    h = 17'd80353;
            8'd8:    h = 17'd75843;
            8'd9:    h = 17'd71586;
            8'd10:   h = 17'd67568;
            8'd11:   h = 17'd63776;
            8'd12:   h = 17'd60196;
            8'd13:   h = 17'd56818;
            8'd14:   h = 17'd53629;
            default: h = '0;
        endcase
        return h;
    endfunction

    function automatic logic is_rest(input note_t idx);
        return (idx == REST_IDX) || (idx > MAX_IDX);
    endfunction

endpackage

// File: rtl/music_player_if.sv
// Control, ROM and audio signals of the music player; master is the
// player itself, slave is the board/ROM side.
interface music_player_if;
    import music_player_pkg::*;

    logic  enable;
    logic  restart;
    note_t noteout;
    logic  [7:0] address;
    logic  speaker;
    note_t cur_note;
    logic  note_strobe;
    logic  done;
    logic  busy;

    modport master (
        input  enable, restart, noteout,
        output address, speaker, cur_note, note_strobe, done, busy
    );

    modport slave (
        output enable, restart, noteout,
        input  address, speaker, cur_note, note_strobe, done, busy
    );

endinterface

// File: rtl/music_player_tone_gen.sv
// Square-wave generator: toggles its output every half_period clocks while
// run is high; clear returns it to a silent, zero-count state.
module music_player_tone_gen
    import music_player_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clear,
    input  logic  run,
    input  half_t half_period,
    output logic  square
);

    half_t cnt_q, cnt_d;
    logic  square_q, square_d;

    always_comb begin
        cnt_d    = cnt_q;
        square_d = square_q;
        if (clear) begin
            cnt_d    = '0;
            square_d = 1'b0;
        end else if (run) begin
            if (cnt_q == half_period - 17'd1) begin
                cnt_d    = '0;
                square_d = ~square_q;
            end else begin
                cnt_d = cnt_q + 17'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            square_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            square_q <= square_d;
        end
    end

    assign square = square_q;

endmodule

// File: rtl/music_player.sv
// Song sequencer: walks the note ROM, holds each note for a tempo slot
// followed by a silent gap, and drives the speaker with the note's tone.
module music_player
    import music_player_pkg::*;
#(
    parameter int NOTE_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 1250000,
    parameter int ROM_LATENCY = 2,
    parameter int DIV_SHIFT   = 0,
    parameter int LOOP        = 1
) (
    input logic            clk,
    input logic            reset,
    music_player_if.master bus
);

    localparam int            DW         = $clog2(NOTE_CYCLES);
    localparam logic [DW-1:0] FETCH_LAST = DW'(ROM_LATENCY);
    localparam logic [DW-1:0] PLAY_LAST  = DW'(NOTE_CYCLES - GAP_CYCLES - 1);
    localparam logic [DW-1:0] GAP_LAST   = DW'(GAP_CYCLES - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] dur_q, dur_d;
    logic [7:0]    addr_q, addr_d;
    note_t         note_q, note_d;
    logic          strobe_q, strobe_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    half_t         shifted, half_period;
    logic          tone_clear, tone_run;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        note_d   = note_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (bus.enable) state_d = ST_FETCH;
            ST_FETCH: if (dur_q == FETCH_LAST) begin
                note_d   = bus.noteout;
                strobe_d = 1'b1;
                state_d  = ST_PLAY;
            end
            ST_PLAY:  if (dur_q == PLAY_LAST) state_d = ST_GAP;
            ST_GAP:   if (dur_q == GAP_LAST) begin
                addr_d = addr_q + 8'd1;
                if (addr_q == 8'hFF && LOOP == 0) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE:  ;
            default:  state_d = ST_IDLE;
        endcase

        // Restart outranks enable, which outranks normal sequencing.
        if (!bus.enable && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            addr_d   = addr_q;
            note_d   = note_q;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end
        if (bus.restart) begin
            state_d  = ST_FETCH;
            addr_d   = 8'd0;
            note_d   = note_q;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end

        if (state_d == state_q && !bus.restart &&
            (state_q == ST_FETCH || state_q == ST_PLAY || state_q == ST_GAP))
            dur_d = dur_q + 1'b1;
        else
            dur_d = '0;

        busy_d = (state_d == ST_FETCH) || (state_d == ST_PLAY) || (state_d == ST_GAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            dur_q    <= '0;
            addr_q   <= '0;
            note_q   <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dur_q    <= dur_d;
            addr_q   <= addr_d;
            note_q   <= note_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Tone runs only while PLAY continues, so entering or leaving PLAY silences it.
    assign shifted     = half_table(note_q) >> DIV_SHIFT;
    assign half_period = (shifted == '0) ? 17'd1 : shifted;
    assign tone_clear  = !(state_q == ST_PLAY && state_d == ST_PLAY);
    assign tone_run    = (state_q == ST_PLAY) && !is_rest(note_q);

    music_player_tone_gen u_tone (
        .clk         (clk),
        .reset       (reset),
        .clear       (tone_clear),
        .run         (tone_run),
        .half_period (half_period),
        .square      (bus.speaker)
    );

    assign bus.address     = addr_q;
    assign bus.cur_note    = note_q;
    assign bus.note_strobe = strobe_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;

endmodule
